param_alu_seq: RTL and testbench
================================

Name: param_alu_seq

Overview:
- Parametrised, handshaked successor of the team's single-cycle four-op ALU (ADD, SUB, MUL, DIV).
- Widens operands to WIDTH, returns a full 2*WIDTH result and replaces the single "correct" bit with per-cause error flags.
- Replaces the combinational divider with an iterative one that takes WIDTH cycles.
- Sits between a testbench/driver interface and a scoreboard. Exactly one operation is in flight at a time, under valid/ready on both sides.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- TAG_W, 4, width of the user tag echoed from request to response.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- mode  in  2  op_t: ADD=0, SUB=1, MUL=2, DIV=3.
- value1  in  WIDTH  operand A (unsigned).
- value2  in  WIDTH  operand B (unsigned).
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts response.
- result  out  2*WIDTH  response data.
- out_tag  out  TAG_W  tag of the response.
- err  out  3  {div_zero, borrow, carry}; the response is correct iff err==0.

Behaviour:
- Reset (reset==0, async):
  - State goes to IDLE.
  - out_valid=0, result=0, out_tag=0, err=0.
  - in_ready=0 while reset is low.
  - Any in-flight divide is discarded; there is no response for it.
- States and transitions:
  - IDLE: in_ready=1. A request is accepted on a rising edge with in_valid && in_ready; mode, operands and tag are captured on that edge.
  - From IDLE, ADD/SUB/MUL and DIV-by-zero go to DONE on that same edge, so out_valid is high on the next cycle (latency 1).
  - From IDLE, DIV with value2!=0 goes to CALC.
  - CALC: restoring divider, one quotient bit per cycle, WIDTH cycles, then DONE. out_valid rises WIDTH+1 cycles after acceptance.
  - DONE: out_valid=1. result, err and out_tag are held stable until out_valid && out_ready on an edge, then the block returns to IDLE.
  - No request is accepted in CALC or DONE (in_ready=0).
  - The DONE->IDLE edge does not also accept a request. The earliest next accept is the following edge (back-to-back throughput: 1 op per 2 cycles).
- Arithmetic (unsigned):
  - ADD: result = zero-extended value1+value2 (WIDTH+1 bits). carry = bit WIDTH of the sum.
  - SUB: result = zero-extended (value1-value2) mod 2^WIDTH. borrow = (value2>value1).
  - MUL: result = full 2*WIDTH product; no error is possible.
  - DIV: result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder.
  - DIV with value2==0: result=0, div_zero=1, and the CALC state is skipped.
  - Only the flag belonging to the current op may be 1; the other flags are 0.
- Boundaries:
  - out_ready may be held high permanently.
  - out_ready low stalls DONE indefinitely with no data change.
  - in_valid may drop without acceptance; there is no side effect.
  - Operand/mode changes on the input while in CALC/DONE are ignored.

Optional Feature:
- Macro ALU_STICKY_ERR_EN.
- Defined:
  - Adds an input err_clear (1) and an output err_sticky (3).
  - err_sticky bits OR-accumulate err on every response handshake.
  - err_clear=1 zeroes err_sticky on the next edge. If err_clear and a handshake occur on the same edge, the clear wins.
  - err_sticky resets to 0.
- Undefined: both ports are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg:
  - op_t enum (ADD, SUB, MUL, DIV; 2-bit).
  - state_t (IDLE, CALC, DONE).
  - Error bit index constants ERR_CARRY=0, ERR_BORROW=1, ERR_DZ=2.
- Sub-module alu_seq_divider:
  - Iterative restoring divider parametrised by WIDTH.
  - Interface: start/busy/done, dividend, divisor, quotient, remainder.
  - Instantiated once; the top-level FSM owns the handshake.

Test Plan (WIDTH=8):
- Reset mid-DIV: accept 200/7, pull reset low at cycle 3 -> out_valid=0 immediately, no response appears, in_ready=1 after reset release.
- ADD 200+100, out_ready=1 -> out_valid one cycle after accept, result=300 (0x012C), err=3'b001; 10+5 -> result=15, err=0.
- SUB 5-9 -> result=0x00FC, err=3'b010; 9-5 -> result=4, err=0.
- MUL 255*255 -> result=0xFE01, err=0.
- DIV 200/7 -> out_valid exactly 9 cycles after accept, result[7:0]=28, result[15:8]=4, err=0; DIV 50/0 -> latency 1, result=0, err=3'b100.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result, err and out_tag stable, in_ready=0; then out_ready=1 -> handshake, IDLE, next request accepted on the following edge. Tags 0..15 are echoed in order.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential four-op ALU.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpMul = 2'd2,
        OpDiv = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam int unsigned ERR_CARRY  = 0;
    localparam int unsigned ERR_BORROW = 1;
    localparam int unsigned ERR_DZ     = 2;

endpackage

// File: rtl/alu_seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles per divide.
module alu_seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] rem_in, quo_in, dsr_in;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] step_rem, step_quo;

    // The first step is taken on the start edge, straight from the operands.
    always_comb begin
        rem_in   = start ? '0 : rem_q;
        quo_in   = start ? dividend : quo_q;
        dsr_in   = start ? divisor : dsr_q;
        shifted  = {rem_in, quo_in[WIDTH-1]};
        trial    = shifted - {1'b0, dsr_in};
        step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        step_quo = {quo_in[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= step_rem;
                quo_q  <= step_quo;
                dsr_q  <= divisor;
                cnt_q  <= CntW'(WIDTH - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/param_alu_seq.sv
// Handshaked four-op ALU with iterative divider and per-cause error flags.
// Optional ALU_STICKY_ERR_EN adds err_clear / err_sticky accumulation.
module param_alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   value1,
    input  logic [WIDTH-1:0]   value2,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [TAG_W-1:0]   out_tag,
`ifdef ALU_STICKY_ERR_EN
    input  logic               err_clear,
    output logic [2:0]         err_sticky,
`endif
    output logic [2:0]         err
);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [2:0]           err_q, err_d;

    logic                 div_start, div_busy, div_done;
    logic [WIDTH-1:0]     div_quo, div_rem;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     diff;
    logic [2*WIDTH-1:0]   prod;
    logic                 accept;

    assign sum    = {1'b0, value1} + {1'b0, value2};
    assign diff   = value1 - value2;
    assign prod   = {{WIDTH{1'b0}}, value1} * {{WIDTH{1'b0}}, value2};
    // Reset is held in in_ready so nothing can be taken while it is asserted.
    assign in_ready = (state_q == StIdle) && reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        tag_d     = tag_q;
        err_d     = err_q;
        div_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tag_d    = in_tag;
                    err_d    = '0;
                    state_d  = StDone;
                    unique case (op_t'(mode))
                        OpAdd: begin
                            result_d         = {{(WIDTH-1){1'b0}}, sum};
                            err_d[ERR_CARRY] = sum[WIDTH];
                        end
                        OpSub: begin
                            result_d          = {{WIDTH{1'b0}}, diff};
                            err_d[ERR_BORROW] = (value2 > value1);
                        end
                        OpMul: result_d = prod;
                        OpDiv: begin
                            result_d = '0;
                            if (value2 == '0) begin
                                err_d[ERR_DZ] = 1'b1;
                            end else begin
                                div_start = 1'b1;
                                state_d   = StCalc;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                if (div_done && !div_busy) begin
                    result_d = {div_rem, div_quo};
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            tag_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
        end
    end

    alu_seq_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (value1),
        .divisor  (value2),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign out_tag   = tag_q;
    assign err       = err_q;

`ifdef ALU_STICKY_ERR_EN
    logic [2:0] sticky_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sticky_q <= '0;
        end else if (err_clear) begin
            sticky_q <= '0;
        end else if (out_valid && out_ready) begin
            sticky_q <= sticky_q | err_q;
        end
    end

    assign err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_param_alu_seq.sv
// Directed bench for param_alu_seq with an expected-response scoreboard.
module tb_param_alu_seq;
    import alu_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  value1 = '0;
    logic [7:0]  value2 = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid;
    logic [15:0] result;
    logic [3:0]  out_tag;
    logic [2:0]  err;
`ifdef ALU_STICKY_ERR_EN
    logic        err_clear = 1'b0;
    logic [2:0]  err_sticky;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [15:0] res;
        logic [2:0]  err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    param_alu_seq #(
        .WIDTH(8),
        .TAG_W(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .value1    (value1),
        .value2    (value2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
`ifdef ALU_STICKY_ERR_EN
        .err_clear (err_clear),
        .err_sticky(err_sticky),
`endif
        .err       (err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input int op, input int a, input int b, input int tag);
        exp_t e;
        e.tag = tag[3:0];
        e.lat = 1;
        e.err = 3'b000;
        case (op)
            0: begin
                e.res = 16'(a + b);
                if (a + b > 255) e.err = 3'b001;
            end
            1: begin
                e.res = 16'((a - b) & 255);
                if (b > a) e.err = 3'b010;
            end
            2: e.res = 16'(a * b);
            default: begin
                if (b == 0) begin
                    e.res = 16'h0000;
                    e.err = 3'b100;
                end else begin
                    e.res = 16'(((a % b) << 8) | (a / b));
                    e.lat = 9;
                end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input int op, input int a, input int b, input int tag, input int stall);
        exp_t        e;
        int          n;
        int          lat;
        logic [15:0] r0;
        logic [2:0]  e0;
        logic [3:0]  t0;
        @(negedge clock);
        mode      = op[1:0];
        value1    = a[7:0];
        value2    = b[7:0];
        in_tag    = tag[3:0];
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("accept_in_time", 32'(n < 50), 32'd1);
        sb.push_back(model(op, a, b, tag));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 1;
        // Scramble the inputs while busy; the captured request must be unaffected.
        while (!out_valid && lat < 100) begin
            value1   = 8'($urandom);
            value2   = 8'($urandom);
            mode     = 2'($urandom);
            in_tag   = 4'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("response_in_time", 32'(out_valid), 32'd1);
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("err", 32'(err), 32'(e.err));
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        chk("latency", 32'(lat), 32'(e.lat));
        r0 = result;
        e0 = err;
        t0 = out_tag;
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", 32'(result), 32'(r0));
            chk("stall_err", 32'(err), 32'(e0));
            chk("stall_tag", 32'(out_tag), 32'(t0));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("valid_after_handshake", 32'(out_valid), 32'd0);
        chk("ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Divide aborted by reset: no response may surface.
        mode     = 2'd3;
        value1   = 8'd200;
        value2   = 8'd7;
        in_tag   = 4'd9;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("calc_in_ready", 32'(in_ready), 32'd0);
        chk("calc_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (15) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        chk("abort_no_response", 32'(seen), 32'd0);

        run_op(0, 200, 100, 0, 0);
        run_op(0, 10, 5, 1, 0);
        run_op(1, 5, 9, 2, 0);
        run_op(1, 9, 5, 3, 0);
        run_op(2, 255, 255, 4, 0);
        run_op(3, 200, 7, 5, 0);
        run_op(3, 50, 0, 6, 0);
        run_op(0, 255, 1, 7, 5);
        for (int t = 8; t < 16; t++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), t, int'($urandom_range(0, 3)));
        end
        run_op(3, 255, 1, 0, 0);
        run_op(3, 3, 200, 1, 0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
